psum_drain_ctrl: RTL and testbench

// - Read-side counterpart of the PE psum chain: after a tile's accumulation, drives the array's

---
 rtl/psum_drain_ctrl.sv | 146 ++++++++++++++
 tb/tb_psum_drain_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl
// Drains accumulated partial sums out of the PE array after a tile. The block
// shifts the psum chain down one row per step and captures the bottom row of
// every column. It presents each captured row as one beat on a valid/ready
// stream. The bottom row is presented first. The array is only shifted after
// the current beat has been accepted, so backpressure never loses a psum.
//
// Optional feature (compile-time macro DRAIN_CLEAR_EN):
//   defined   - FINISH issues one extra shift alongside done. With the array's
//               top-row psum_in tied to 0, this leaves every PE at zero
//               (ROWS shifts per drain).
//   undefined - FINISH only pulses done (ROWS-1 shifts per drain). The array
//               keeps shifted, stale psums.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start_drain  in   drain request, honoured only while idle
//   col_psum_in  in   bottom-row psums, column c at [c*PSUM_W +: PSUM_W]
//   set_reg      out  array register enable, high on shift cycles only
//   sel_mux      out  array psum_in select (shift), high on shift cycles only
//   drain_busy   out  high whenever the controller is not idle
//   out_valid    out  out_data holds a captured row
//   out_ready    in   downstream accepts the beat when out_valid && out_ready
//   out_data     out  captured row, same packing as col_psum_in
//   out_row_idx  out  array row of the current beat (ROWS-1 down to 0)
//   out_last     out  high with the row-0 beat
//   done         out  single-cycle pulse when the drain completes
module psum_drain_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    localparam int PSUM_W     = 2 * DATA_WIDTH,
    localparam int IDX_W      = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_drain,
    input  logic [COLS*PSUM_W-1:0]   col_psum_in,
    output logic                     set_reg,
    output logic                     sel_mux,
    output logic                     drain_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*PSUM_W-1:0]   out_data,
    output logic [IDX_W-1:0]         out_row_idx,
    output logic                     out_last,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PRESENT,
        SHIFT,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic              accept;

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= IDX_W'(ROWS - 1);
            out_data    <= '0;
            out_row_idx <= '0;
            out_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_drain) begin
                        cnt <= IDX_W'(ROWS - 1);
                    end
                end
                CAPTURE: begin
                    out_data    <= col_psum_in;
                    out_row_idx <= cnt;
                    out_valid   <= 1'b1;
                end
                PRESENT: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The array shifts at the end of SHIFT. The following CAPTURE then sees
    // the new bottom row, so shift enables are decoded straight from state.
    always_comb begin
        state_nxt = state;
        set_reg   = 1'b0;
        sel_mux   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_drain) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    state_nxt = (cnt == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                set_reg   = 1'b1;
                sel_mux   = 1'b1;
                state_nxt = CAPTURE;
            end
            FINISH: begin
                done      = 1'b1;
`ifdef DRAIN_CLEAR_EN
                // Final shift pulls zeros in from the top, clearing the array.
                set_reg   = 1'b1;
                sel_mux   = 1'b1;
`else
                set_reg   = 1'b0;
                sel_mux   = 1'b0;
`endif
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign drain_busy = (state != IDLE);
    assign out_last   = out_valid && (out_row_idx == '0);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Self-checking bench for psum_drain_ctrl (4x4 array, 16-bit psums).
// A small array model shifts rows down on set_reg && sel_mux and feeds its
// bottom row back as col_psum_in. It is preloaded with row r, col c = 16*r+c.
// Expectations follow the DRAIN_CLEAR_EN build option.
module tb_psum_drain_ctrl;
    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int PW   = 2 * DW;
    localparam int IW   = 2;
`ifdef DRAIN_CLEAR_EN
    localparam int EXP_SHIFTS  = 4;
    localparam int EXP_BOT_SUM = 0;
`else
    localparam int EXP_SHIFTS  = 3;
    localparam int EXP_BOT_SUM = 6;   // row 0 (0+1+2+3) ends up at the bottom
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_drain = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 load = 1'b0;
    logic [COLS*PW-1:0]   col_psum_in;
    logic [COLS*PW-1:0]   out_data;
    logic                 set_reg, sel_mux, drain_busy, out_valid, out_last, done;
    logic [IW-1:0]        out_row_idx;
    logic [PW-1:0]        arr [ROWS][COLS];
    int                   n_cmp = 0;
    int                   n_bad = 0;

    always #5 clk = ~clk;

    psum_drain_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start_drain(start_drain),
        .col_psum_in(col_psum_in), .set_reg(set_reg), .sel_mux(sel_mux),
        .drain_busy(drain_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last),
        .done(done)
    );

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_psum_in[c*PW +: PW] = arr[ROWS-1][c];
    end

    // Array model: row ROWS-1 is the bottom; the top row's psum_in is tied 0.
    always @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    arr[r][c] <= PW'(16 * r + c);
        end else if (set_reg && sel_mux) begin
            for (int r = ROWS - 1; r > 0; r--)
                for (int c = 0; c < COLS; c++)
                    arr[r][c] <= arr[r-1][c];
            for (int c = 0; c < COLS; c++)
                arr[0][c] <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] row_vec(input int r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++)
            v[c*PW +: PW] = PW'(16 * r + c);
        return v;
    endfunction

    task automatic preload();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_array();
        int bot = 0;
        int rest = 0;
        for (int c = 0; c < COLS; c++) begin
            bot += int'(arr[ROWS-1][c]);
            for (int r = 0; r < ROWS - 1; r++)
                rest += int'(arr[r][c]);
        end
        check("array_bottom_sum", 64'(bot), 64'(EXP_BOT_SUM));
        check("array_upper_sum", 64'(rest), 64'd0);
    endtask

    // Runs one drain from a negedge. stall_beat >= 0 holds out_ready low for
    // 10 cycles on that beat. poke re-pulses start_drain during beat 0 and in
    // the done cycle.
    task automatic run_drain(input int stall_beat, input bit poke);
        int beats = 0;
        int shifts = 0;
        int dones = 0;
        int stall = 0;
        int last_acc = -100;
        int done_cyc = -1;
        logic rdy;
        start_drain = 1'b1;
        @(negedge clk);
        start_drain = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc == 0) check("capture_not_valid", 64'(out_valid), 64'd0);
            if (cyc == 1) check("first_valid", 64'(out_valid), 64'd1);
            if (set_reg != sel_mux) check("set_eq_sel", 64'(sel_mux), 64'(set_reg));
            if (set_reg && sel_mux) shifts++;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("done_after_last", 64'(cyc - last_acc), 64'd1);
                end
                if (poke) start_drain = 1'b1;
            end
            rdy = !(beats == stall_beat && stall < 10);
            if (out_valid && !rdy) begin
                stall++;
                check("stall_data", out_data, row_vec(ROWS - 1 - beats));
                check("stall_idx", 64'(out_row_idx), 64'(ROWS - 1 - beats));
                check("stall_set_reg", 64'(set_reg), 64'd0);
            end
            if (out_valid && rdy) begin
                check("beat_idx", 64'(out_row_idx), 64'(ROWS - 1 - beats));
                check("beat_data", out_data, row_vec(ROWS - 1 - beats));
                check("beat_last", 64'(out_last), 64'(beats == ROWS - 1));
                if (beats > 0 && beats != stall_beat)
                    check("beat_spacing", 64'(cyc - last_acc), 64'd3);
                if (poke && beats == 0) start_drain = 1'b1;
                last_acc = cyc;
                beats++;
            end
            out_ready = rdy;
            if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
            @(negedge clk);
            start_drain = 1'b0;
        end
        start_drain = 1'b0;
        out_ready = 1'b1;
        check("beat_count", 64'(beats), 64'(ROWS));
        check("done_count", 64'(dones), 64'd1);
        check("shift_count", 64'(shifts), 64'(EXP_SHIFTS));
        check("idle_after", 64'(drain_busy), 64'd0);
        if (stall_beat >= 0) check("stall_cycles", 64'(stall), 64'd10);
        check_array();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({set_reg, sel_mux, drain_busy, out_valid, out_last, done, out_row_idx}), 64'd0);
        check("reset_data", out_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain drain with out_ready held high.
        preload();
        run_drain(-1, 1'b0);

        // Backpressure on the second beat (row 2).
        preload();
        run_drain(1, 1'b0);

        // start_drain poked while busy and in the done cycle.
        preload();
        run_drain(-1, 1'b1);

        // Asynchronous reset during the SHIFT that follows the row-2 beat.
        preload();
        found = 1'b0;
        start_drain = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start_drain = 1'b0;
            if (set_reg && out_row_idx == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_shift_row2", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({set_reg, sel_mux, drain_busy, out_valid, out_last, done, out_row_idx}), 64'd0);
        check("async_reset_data", out_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        preload();
        run_drain(-1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
